// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS datapath: opcodes, functs,
// ALU-control encoding, FSM states and the R-type funct decoder.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2a;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_NOR = 4'd4,
        ALU_SLT = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7
    } alu_op_e;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB
    } state_e;

    typedef struct packed {
        logic    valid;
        alu_op_e op;
    } funct_dec_t;

    function automatic funct_dec_t funct_decode(input logic [5:0] funct);
        funct_dec_t d;
        d.valid = 1'b1;
        d.op    = ALU_ADD;
        case (funct)
            FN_ADD:  d.op = ALU_ADD;
            FN_SUB:  d.op = ALU_SUB;
            FN_AND:  d.op = ALU_AND;
            FN_OR:   d.op = ALU_OR;
            FN_NOR:  d.op = ALU_NOR;
            FN_SLT:  d.op = ALU_SLT;
            FN_SLL:  d.op = ALU_SLL;
            FN_SRL:  d.op = ALU_SRL;
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mc_regfile.sv
// 32 x WIDTH register file: two asynchronous read ports, one synchronous
// write port, synchronous clear; r0 always reads zero and ignores writes.
module mc_regfile
    import mc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ra1,
    input  logic [4:0]       ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic             we,
    input  logic [4:0]       wa,
    input  logic [WIDTH-1:0] wd
);

    logic [WIDTH-1:0] regs_q [32];
    logic [WIDTH-1:0] regs_d [32];

    always_comb begin
        regs_d = regs_q;
        if (we && (wa != 5'd0)) begin
            regs_d[wa] = wd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? '0 : regs_q[ra1];
    assign rd2 = (ra2 == 5'd0) ? '0 : regs_q[ra2];

endmodule

// File: rtl/mc_datapath.sv
// Multi-cycle MIPS-subset datapath with embedded control FSM and req/ack
// memory ports. Define MC_JUMP_EN to add j/jal; otherwise they are illegal.
module mc_datapath
    import mc_pkg::*;
#(
    parameter int                  WIDTH    = 32,
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_rdata,
    input  logic                imem_ack,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [WIDTH-1:0]    dmem_addr,
    output logic [WIDTH-1:0]    dmem_wdata,
    input  logic [WIDTH-1:0]    dmem_rdata,
    input  logic                dmem_ack,
    output logic [PC_WIDTH-1:0] pc,
    output logic                retire,
    output logic                illegal
);

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] target_q, target_d;
    logic [31:0]         ir_q, ir_d;
    logic [WIDTH-1:0]    a_q, a_d;
    logic [WIDTH-1:0]    b_q, b_d;
    logic [WIDTH-1:0]    aluout_q, aluout_d;
    logic [WIDTH-1:0]    mdr_q, mdr_d;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;

    assign opcode = ir_q[31:26];
    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign shamt  = ir_q[10:6];
    assign funct  = ir_q[5:0];
    assign imm    = ir_q[15:0];

    logic [WIDTH-1:0]    imm_sext, alu_b, alu_y, rs_val, rt_val, rf_wd;
    logic [PC_WIDTH-1:0] pc4, br_off;
    logic                legal, shift_big, rf_we;
    logic [4:0]          rf_wa;
    alu_op_e             alu_op;
    funct_dec_t          fdec;
    logic                imem_req_c, dmem_req_c, retire_c, illegal_c;

    assign imm_sext  = WIDTH'($signed(imm));
    assign br_off    = PC_WIDTH'($signed({imm, 2'b00}));
    assign pc4       = pc_q + PC_WIDTH'(32'd4);
    assign alu_b     = (opcode == OP_RTYPE) ? b_q : imm_sext;
    assign shift_big = (32'(shamt) >= WIDTH);

`ifdef MC_JUMP_EN
    logic [PC_WIDTH-1:0] jump_target;
    // Bits above 27 come from pc+4; the mask degrades gracefully for narrow or wide PCs.
    assign jump_target = (pc4 & ~PC_WIDTH'(32'h0FFF_FFFF)) | PC_WIDTH'({ir_q[25:0], 2'b00});
`endif

    mc_regfile #(.WIDTH(WIDTH)) u_rf (
        .clk   (clk),
        .reset (reset),
        .ra1   (rs),
        .ra2   (rt),
        .rd1   (rs_val),
        .rd2   (rt_val),
        .we    (rf_we),
        .wa    (rf_wa),
        .wd    (rf_wd)
    );

    always_comb begin
        fdec   = funct_decode(funct);
        legal  = 1'b0;
        alu_op = ALU_ADD;
        case (opcode)
            OP_RTYPE: begin
                legal  = fdec.valid;
                alu_op = fdec.op;
            end
            OP_LW, OP_SW, OP_ADDI, OP_BEQ: legal = 1'b1;
`ifdef MC_JUMP_EN
            OP_J, OP_JAL: legal = 1'b1;
`endif
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        alu_y = '0;
        case (alu_op)
            ALU_ADD: alu_y = a_q + alu_b;
            ALU_SUB: alu_y = a_q - alu_b;
            ALU_AND: alu_y = a_q & alu_b;
            ALU_OR:  alu_y = a_q | alu_b;
            ALU_NOR: alu_y = ~(a_q | alu_b);
            ALU_SLT: alu_y = WIDTH'($signed(a_q) < $signed(alu_b));
            ALU_SLL: alu_y = shift_big ? '0 : (b_q << shamt);
            ALU_SRL: alu_y = shift_big ? '0 : (b_q >> shamt);
            default: alu_y = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        target_d   = target_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        aluout_d   = aluout_q;
        mdr_d      = mdr_q;
        rf_we      = 1'b0;
        rf_wa      = rd;
        rf_wd      = aluout_q;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        retire_c   = 1'b0;
        illegal_c  = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req_c = 1'b1;
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d      = rs_val;
                b_d      = rt_val;
                target_d = pc4 + br_off;
                state_d  = S_EXEC;
            end
            S_EXEC: begin
                aluout_d = alu_y;
                if (!legal) begin
                    pc_d      = pc4;
                    retire_c  = 1'b1;
                    illegal_c = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    case (opcode)
                        OP_BEQ: begin
                            pc_d     = (a_q == b_q) ? target_q : pc4;
                            retire_c = 1'b1;
                            state_d  = S_FETCH;
                        end
                        OP_LW, OP_SW: state_d = S_MEM;
`ifdef MC_JUMP_EN
                        OP_J: begin
                            pc_d     = jump_target;
                            retire_c = 1'b1;
                            state_d  = S_FETCH;
                        end
                        OP_JAL: begin
                            pc_d     = jump_target;
                            rf_we    = 1'b1;
                            rf_wa    = 5'd31;
                            rf_wd    = WIDTH'(pc4);
                            retire_c = 1'b1;
                            state_d  = S_FETCH;
                        end
`endif
                        default: state_d = S_WB;
                    endcase
                end
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                if (dmem_ack) begin
                    if (opcode == OP_LW) begin
                        mdr_d   = dmem_rdata;
                        state_d = S_WB;
                    end else begin
                        pc_d     = pc4;
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end
                end
            end
            S_WB: begin
                rf_we    = 1'b1;
                rf_wa    = (opcode == OP_RTYPE) ? rd : rt;
                rf_wd    = (opcode == OP_LW) ? mdr_q : aluout_q;
                pc_d     = pc4;
                retire_c = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            target_q <= '0;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            mdr_q    <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            aluout_q <= aluout_d;
            mdr_q    <= mdr_d;
        end
    end

    // Reset masks requests and pulses so nothing leaks while it is held.
    assign imem_req   = imem_req_c & ~reset;
    assign dmem_req   = dmem_req_c & ~reset;
    assign retire     = retire_c & ~reset;
    assign illegal    = illegal_c & ~reset;
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign dmem_we    = (opcode == OP_SW);
    assign dmem_addr  = aluout_q;
    assign dmem_wdata = b_q;

endmodule

// File: tb/tb_mc_datapath.sv
// Directed plus randomized bench for mc_datapath against an instruction-level
// reference model that predicts pc, register state, memory traffic and latency.
module tb_mc_datapath;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [31:0] pc;
    logic        retire, illegal;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mc_datapath #(
        .WIDTH    (32),
        .PC_WIDTH (32),
        .RESET_PC (32'h100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .pc         (pc),
        .retire     (retire),
        .illegal    (illegal)
    );

    logic [31:0] m_rf [32];
    logic [31:0] m_pc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] f, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh);
        return {6'h00, rs, rt, rd, sh, f};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_rf[i] = '0;
        m_pc = 32'h100;
    endtask

    // Architectural effect of one instruction; updates m_rf/m_pc.
    task automatic model(input logic [31:0] ins, input logic [31:0] ld,
                         output int base, output bit mem, output bit we,
                         output logic [31:0] addr, output logic [31:0] wdata, output bit ill);
        logic [31:0] s, t, simm, nxt, wval;
        logic [4:0]  wreg;
        bit          wr;
        s    = m_rf[ins[25:21]];
        t    = m_rf[ins[20:16]];
        simm = {{16{ins[15]}}, ins[15:0]};
        nxt  = m_pc + 4;
        base = 3; mem = 0; we = 0; addr = '0; wdata = '0; ill = 0;
        wr = 0; wreg = '0; wval = '0;
        case (ins[31:26])
            6'h00: begin
                base = 4; wr = 1; wreg = ins[15:11];
                case (ins[5:0])
                    6'h20: wval = s + t;
                    6'h22: wval = s - t;
                    6'h24: wval = s & t;
                    6'h25: wval = s | t;
                    6'h27: wval = ~(s | t);
                    6'h2a: wval = ($signed(s) < $signed(t)) ? 32'd1 : 32'd0;
                    6'h00: wval = t << ins[10:6];
                    6'h02: wval = t >> ins[10:6];
                    default: begin ill = 1; wr = 0; base = 3; end
                endcase
            end
            6'h08: begin base = 4; wr = 1; wreg = ins[20:16]; wval = s + simm; end
            6'h23: begin base = 5; mem = 1; addr = s + simm; wr = 1; wreg = ins[20:16]; wval = ld; end
            6'h2b: begin base = 4; mem = 1; we = 1; addr = s + simm; wdata = t; end
            6'h04: if (s == t) nxt = m_pc + 4 + (simm << 2);
`ifdef MC_JUMP_EN
            6'h02: nxt = {nxt[31:28], ins[25:0], 2'b00};
            6'h03: begin wr = 1; wreg = 5'd31; wval = m_pc + 4; nxt = {nxt[31:28], ins[25:0], 2'b00}; end
`endif
            default: ill = 1;
        endcase
        if (wr && wreg != 5'd0) m_rf[wreg] = wval;
        m_pc = nxt;
    endtask

    // Drives one instruction through the DUT with iw fetch and dw data wait cycles.
    task automatic run_instr(input logic [31:0] ins, input int iw, input int dw, input logic [31:0] ld);
        int          base, cyc, fcnt, mcnt, exp_cyc;
        bit          mem, we, ill, fetched, macked, done;
        logic [31:0] addr, wdata, pc0;
        pc0 = m_pc;
        model(ins, ld, base, mem, we, addr, wdata, ill);
        exp_cyc = base + iw + (mem ? dw : 0);
        cyc = 0; fcnt = 0; mcnt = 0; fetched = 0; macked = 0; done = 0;
        while (!done && cyc < 64) begin
            @(negedge clk);
            cyc++;
            imem_ack = 1'b0; imem_rdata = '0;
            dmem_ack = 1'b0; dmem_rdata = '0;
            if (fetched) begin
                chk("imem_req_after_ack", imem_req, 0);
            end else if (imem_req) begin
                chk("imem_addr", imem_addr, pc0);
                if (fcnt == iw) begin
                    imem_ack = 1'b1; imem_rdata = ins; fetched = 1;
                end
                fcnt++;
            end
            if (!mem || macked) begin
                chk("dmem_req_idle", dmem_req, 0);
            end else if (dmem_req) begin
                chk("dmem_we", dmem_we, we);
                chk("dmem_addr", dmem_addr, addr);
                if (we) chk("dmem_wdata", dmem_wdata, wdata);
                if (mcnt == dw) begin
                    dmem_ack = 1'b1; dmem_rdata = ld; macked = 1;
                end
                mcnt++;
            end
            #1;
            if (retire) begin
                done = 1;
                chk("illegal_at_retire", illegal, ill);
            end else begin
                chk("illegal_without_retire", illegal, 0);
            end
        end
        chk("retire_seen", done, 1);
        chk("cycle_count", cyc, exp_cyc);
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        chk("pc_after", pc, m_pc);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0]  fn_tbl [8];
        logic [5:0]  bad_op [4];
        logic [31:0] ins, d, pc_prev;
        int          kind;

        fn_tbl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h00, 6'h02};
        bad_op = '{6'h02, 6'h3f, 6'h0d, 6'h10};

        reset = 1'b1;
        imem_ack = 1'b0; imem_rdata = '0;
        dmem_ack = 1'b0; dmem_rdata = '0;
        model_reset();

        // Reset and first fetch
        repeat (2) @(posedge clk);
        @(negedge clk);
        imem_ack = 1'b1;
        #1;
        chk("rst_imem_req", imem_req, 0);
        chk("rst_dmem_req", dmem_req, 0);
        chk("rst_retire", retire, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_dmem_we", dmem_we, 0);
        chk("rst_pc", pc, 32'h100);
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
        reset = 1'b0;
        #1;
        chk("first_imem_req", imem_req, 1);
        chk("first_imem_addr", imem_addr, 32'h100);

        // addi/addi/add, zero wait
        run_instr(enc_i(6'h08, 5'd0, 5'd1, 16'd5), 0, 0, 0);
        run_instr(enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD), 0, 0, 0);
        run_instr(enc_r(6'h20, 5'd1, 5'd2, 5'd3, 5'd0), 0, 0, 0);
        chk("pc_after_three", pc, 32'h10C);

        // sw with 3 wait cycles, lw with 2, then read r4 back through a store
        run_instr(enc_i(6'h2b, 5'd0, 5'd3, 16'd8), 0, 3, 0);
        run_instr(enc_i(6'h23, 5'd0, 5'd4, 16'd8), 0, 2, 32'd2);
        run_instr(enc_i(6'h2b, 5'd0, 5'd4, 16'd0), 1, 0, 0);

        // beq taken back onto itself, then not taken
        pc_prev = m_pc;
        run_instr(enc_i(6'h04, 5'd1, 5'd1, 16'hFFFF), 0, 0, 0);
        chk("beq_self", pc, pc_prev);
        run_instr(enc_i(6'h04, 5'd1, 5'd2, 16'd5), 0, 0, 0);
        chk("beq_not_taken", pc, pc_prev + 4);

`ifdef MC_JUMP_EN
        d = 32'h20 - m_pc - 32'd4;
        run_instr(enc_i(6'h04, 5'd0, 5'd0, d[17:2]), 0, 0, 0);
        chk("pc_at_0x20", pc, 32'h20);
        run_instr({6'h03, 26'h40}, 0, 0, 0);
        chk("jal_target", pc, 32'h100);
        run_instr(enc_i(6'h2b, 5'd0, 5'd31, 16'd0), 0, 0, 0);
`else
        run_instr(enc_i(6'h02, 5'd1, 5'd5, 16'h1234), 0, 0, 0);
        run_instr(enc_i(6'h2b, 5'd0, 5'd5, 16'd0), 0, 0, 0);
`endif

        // Reset in the middle of a pending store
        @(negedge clk);
        imem_ack = 1'b1; imem_rdata = enc_i(6'h2b, 5'd0, 5'd3, 16'd8);
        @(negedge clk);
        imem_ack = 1'b0; imem_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("mid_mem_req", dmem_req, 1);
        reset = 1'b1;
        dmem_ack = 1'b1;
        #1;
        chk("mid_rst_no_retire", retire, 0);
        @(posedge clk);
        #1;
        chk("mid_rst_dmem_req", dmem_req, 0);
        chk("mid_rst_pc", pc, 32'h100);
        reset = 1'b0;
        dmem_ack = 1'b0;
        model_reset();
        run_instr(enc_i(6'h2b, 5'd0, 5'd3, 16'd8), 0, 0, 0);

        // r0 stays zero
        run_instr(enc_i(6'h08, 5'd0, 5'd0, 16'd7), 0, 0, 0);
        run_instr(enc_i(6'h2b, 5'd0, 5'd0, 16'd4), 0, 1, 0);

        // Random instruction mix with random wait states
        for (int n = 0; n < 60; n++) begin
            kind = int'($urandom_range(0, 9));
            case (kind)
                0, 1, 2: ins = enc_r(fn_tbl[$urandom_range(0, 7)], 5'($urandom_range(0, 7)),
                                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                     5'($urandom_range(0, 31)));
                3, 4:    ins = enc_i(6'h08, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                     16'($urandom));
                5:       ins = enc_i(6'h23, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                     16'($urandom));
                6:       ins = enc_i(6'h2b, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                     16'($urandom));
                7:       ins = enc_i(6'h04, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                                     16'($urandom_range(0, 8)));
                8:       ins = enc_r(6'h21, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                                     5'($urandom_range(1, 7)), 5'd0);
                default: ins = enc_i(bad_op[$urandom_range(0, 3)], 5'd1, 5'($urandom_range(1, 7)),
                                     16'($urandom));
            endcase
            run_instr(ins, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), $urandom);
        end

        // Dump every register through stores
        for (int r = 1; r < 32; r++) begin
            run_instr(enc_i(6'h2b, 5'd0, 5'(r), 16'(r * 4)), 0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
